// File: rtl/alu_pipelined.sv
// Pipelined ALU with valid/ready handshake, registered result and {N,V,C,Z} flags.
// Single-cycle ops complete in one cycle; MUL is an iterative shift-add over WIDTH cycles.
module alu_pipelined #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  instruction,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_NAND = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_ADC  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  logic [0:0]       state, state_next;
  logic [WIDTH-1:0] mul_a, mul_b, mul_acc, mul_sum;
  logic [CNT_W-1:0] mul_cnt;
  logic [3:0]       op;
  logic             accept, mul_last;
  logic             unused_instr;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_c, alu_v, load_res, load_flags;
  logic [WIDTH:0]   add_full, shl_full, shr_full;
  logic             shamt_big;

  assign op           = instruction[3:0];
  assign unused_instr = ^instruction;
  assign in_ready     = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign mul_last     = (state == ST_MUL) && (mul_cnt == CNT_W'(WIDTH - 1));
  assign mul_sum      = mul_acc + (mul_b[0] ? mul_a : '0);

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && (op == OP_MUL)) state_next = ST_MUL;
      ST_MUL:  if (mul_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Single-cycle datapath; carry-out of shifts lands in bit WIDTH (SHL) or bit 0 (SHR)
  always_comb begin
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    load_res   = 1'b1;
    load_flags = 1'b1;
    add_full   = '0;
    shamt_big  = (input_2 >= WIDTH_V);
    shl_full   = {1'b0, input_1} << input_2;
    shr_full   = {input_1, 1'b0} >> input_2;
    case (op)
      OP_OR:   alu_res = input_1 | input_2;
      OP_NAND: alu_res = ~(input_1 & input_2);
      OP_NOR:  alu_res = ~(input_1 | input_2);
      OP_AND:  alu_res = input_1 & input_2;
      OP_XOR:  alu_res = input_1 ^ input_2;
      OP_ADD, OP_ADC: begin
        add_full = {1'b0, input_1} + {1'b0, input_2}
                 + (WIDTH + 1)'((op == OP_ADC) ? flags[1] : 1'b0);
        alu_res  = add_full[WIDTH-1:0];
        alu_c    = add_full[WIDTH];
        alu_v    = (input_1[MSB] == input_2[MSB]) && (alu_res[MSB] != input_1[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res  = input_1 - input_2;
        alu_c    = (input_1 >= input_2);
        alu_v    = (input_1[MSB] != input_2[MSB]) && (alu_res[MSB] != input_1[MSB]);
        load_res = (op == OP_SUB);
      end
      OP_SHL: begin
        alu_res = shamt_big ? '0 : shl_full[WIDTH-1:0];
        alu_c   = shamt_big ? 1'b0 : shl_full[WIDTH];
      end
      OP_SHR: begin
        alu_res = shamt_big ? '0 : shr_full[WIDTH:1];
        alu_c   = shamt_big ? 1'b0 : shr_full[0];
      end
      OP_MUL: begin
        load_res   = 1'b0;
        load_flags = 1'b0;
      end
      default: load_flags = 1'b0;
    endcase
    alu_flags = {alu_res[MSB], alu_v, alu_c, (alu_res == '0)};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Result/flag registers, output handshake and multiplier datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
    end else begin
      if (accept && (op != OP_MUL)) begin
        if (load_res)   result <= alu_res;
        if (load_flags) flags  <= alu_flags;
        out_valid <= 1'b1;
      end else if (mul_last) begin
        result    <= mul_sum;
        flags     <= {mul_sum[MSB], 1'b0, 1'b0, (mul_sum == '0)};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && (op == OP_MUL)) begin
        mul_a   <= input_1;
        mul_b   <= input_2;
        mul_acc <= '0;
        mul_cnt <= '0;
      end else if (state == ST_MUL) begin
        mul_acc <= mul_sum;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        mul_cnt <= mul_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_pipelined.md
Name: alu_pipelined

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU used in the Overture datapath. Keeps the same 3-bit opcode meanings for OR/NAND/NOR/AND/ADD/SUB and adds XOR, shifts, add-with-carry, compare and an iterative multiply. Adds a registered status-flag set. Sits between the register file and the writeback mux. Results are registered and returned over a valid/ready handshake, so it can stall the pipeline during multi-cycle multiply.

Parameters:
WIDTH, 8, data width of operands and result (>=4)
OP_W, 8, width of the instruction field; only bits [3:0] are decoded

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation request present
in_ready  out  1  block can accept a request this cycle
instruction  in  OP_W  opcode in bits [3:0]; upper bits ignored
input_1  in  WIDTH  operand A
input_2  in  WIDTH  operand B (shift amount for shifts)
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer takes the result this cycle
result  out  WIDTH  registered result
flags  out  4  registered {N,V,C,Z}

Behaviour:
- Reset (sync, active-high; the only reset): result=0, flags=0, out_valid=0, state=IDLE, multiply registers=0. Reset asserted mid-multiply aborts it; nothing is produced.
- Accept: in_valid && in_ready; operands and opcode are captured that edge. in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back throughput is 1/cycle for single-cycle ops.
- Opcodes [3:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (A-B), 6 XOR, 7 SHL, 8 SHR (logical), 9 ADC (A+B+C_flag), 10 CMP, 11 MUL (low WIDTH bits of A*B), 12-15 reserved.
- Single-cycle ops (0-10, 12-15): result and flags are registered on the accept edge. out_valid=1 the next cycle (latency 1).
- CMP: computes A-B and updates flags; result register is left unchanged but out_valid still pulses.
- Reserved opcodes: result=0, flags unchanged, out_valid asserted.
- MUL FSM:
  - IDLE -> MUL on accept. Shift-add over exactly WIDTH cycles; in_ready=0 throughout.
  - MUL -> IDLE after the WIDTH-th iteration, loading result and asserting out_valid.
  - Latency from accept to out_valid = WIDTH+1 cycles.
- out_valid holds, and result/flags stay stable, until out_ready is high. A result consumed and a new accept on the same edge is legal; out_valid stays 1 with the new data.
- Flags are updated with every result, not held across ops:
  - Z = (result==0); for CMP, computed on the difference.
  - N = result MSB.
  - C: ADD/ADC = carry-out. SUB/CMP = 1 iff A>=B unsigned. SHL/SHR = last bit shifted out (0 if amount is 0 or >=WIDTH). Logic ops and MUL = 0.
  - V: signed overflow for ADD/ADC/SUB/CMP; 0 otherwise.
- Shifts: amount = full input_2 unsigned; amount >= WIDTH gives result 0.
- Arithmetic is modulo 2^WIDTH; MUL upper half is discarded.

Test Plan:
- Reset then idle: assert rst 2 cycles -> result=0, flags=0, out_valid=0, in_ready=1.
- ADD overflow, WIDTH=8: A=0x7F, B=0x01, op 4 -> next cycle result=0x80, flags N=1,V=1,C=0,Z=0.
- SUB/CMP: A=0x05, B=0x05, op 10 -> result unchanged, Z=1, C=1. Then op 5 with A=0x03, B=0x05 -> result=0xFE, C=0, N=1.
- ADC chain: ADD 0xFF+0x01 (result 0x00, C=1), then ADC 0x00+0x00 -> result=0x01, C=0.
- MUL with backpressure: A=0x0D, B=0x0B, op 11 -> in_ready=0 for 8 cycles, out_valid at cycle 9 with result=0x8F. Hold out_ready=0 for 3 cycles -> result stable and in_ready=0. Apply rst mid-multiply on a second MUL -> out_valid never rises.
- Shifts and streaming: SHL 0x81 by 1 -> 0x02, C=1. SHR 0x80 by 9 -> 0x00, C=0. Four back-to-back ops with out_ready=1 -> four consecutive out_valid cycles.
